// File: rtl/seg_scan_driver_if.sv
// Bus between the display selector and the seven-segment scan driver.
// The selector side (master) supplies the eight display codes; the driver
// side (slave) returns the segment bus, digit commons and frame marker.
interface seg_scan_driver_if;
   logic [3:0] bcd_in1;
   logic [3:0] bcd_in2;
   logic [3:0] bcd_in3;
   logic [3:0] bcd_in4;
   logic [3:0] bcd_in5;
   logic [3:0] bcd_in6;
   logic [3:0] bcd_in7;
   logic [3:0] bcd_in_led;
   logic [7:0] seg;
   logic [7:0] com;
   logic       frame_start;

   modport master (
      output bcd_in1, bcd_in2, bcd_in3, bcd_in4,
             bcd_in5, bcd_in6, bcd_in7, bcd_in_led,
      input  seg, com, frame_start
   );

   modport slave (
      input  bcd_in1, bcd_in2, bcd_in3, bcd_in4,
             bcd_in5, bcd_in6, bcd_in7, bcd_in_led,
      output seg, com, frame_start
   );
endinterface

// File: rtl/seg_scan_driver.sv
// Eight-digit time-multiplexed seven-segment scan driver.
// All eight codes are captured together at the start of each frame so a
// frame never mixes old and new digits. Each digit slot begins with a short
// blank period (all commons off) to suppress ghosting. Segments and commons
// are active-low and fully registered.
module seg_scan_driver #(
   parameter int SCAN_DIV     = 5000,
   parameter int BLANK_CYCLES = 50
) (
   input logic              clk,
   input logic              rst_n,
   seg_scan_driver_if.slave bus
);

   localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [2:0]       idx;
   logic [2:0]       idx_next;
   logic [7:0][3:0]  snap;
   logic [7:0][3:0]  snap_next;
   logic             capture;

   logic [7:0] seg_q;
   logic [7:0] com_q;
   logic       frame_q;
   logic [7:0] seg_next;
   logic [7:0] com_next;
   logic       frame_next;

   // Code to active-low segment pattern; dp is always off.
   function automatic logic [7:0] decode(input logic [3:0] code);
      logic [7:0] pattern;
      case (code)
         4'd0:    pattern = 8'hC0;
         4'd1:    pattern = 8'hF9;
         4'd2:    pattern = 8'hA4;
         4'd3:    pattern = 8'hB0;
         4'd4:    pattern = 8'h99;
         4'd5:    pattern = 8'h92;
         4'd6:    pattern = 8'h82;
         4'd7:    pattern = 8'hF8;
         4'd8:    pattern = 8'h80;
         4'd9:    pattern = 8'h90;
         4'd11:   pattern = 8'hBF;
         default: pattern = 8'hFF;
      endcase
      return pattern;
   endfunction

   // Advance the slot timer and take the frame snapshot at slot 0, cycle 0.
   always_comb begin
      capture  = (cnt == '0) && (idx == 3'd0);
      cnt_next = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      idx_next = (cnt == CNT_LAST) ? idx + 3'd1 : idx;
      snap_next = snap;
      if (capture) begin
         snap_next = {bus.bcd_in_led, bus.bcd_in7, bus.bcd_in6, bus.bcd_in5,
                      bus.bcd_in4, bus.bcd_in3, bus.bcd_in2, bus.bcd_in1};
      end
   end

   // Output values for this edge, decoded from the snapshot as it will be
   // after this edge so the capture cycle never shows stale data.
   always_comb begin
      frame_next = capture;
      com_next   = 8'hFF;
      seg_next   = 8'hFF;
      if (cnt >= BLANK_END) begin
         com_next = ~(8'd1 << idx);
         seg_next = decode(snap_next[idx]);
      end
   end

   // Scan state and output registers; reset blanks the display at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         idx     <= 3'd0;
         snap    <= '0;
         seg_q   <= 8'hFF;
         com_q   <= 8'hFF;
         frame_q <= 1'b0;
      end else begin
         cnt     <= cnt_next;
         idx     <= idx_next;
         snap    <= snap_next;
         seg_q   <= seg_next;
         com_q   <= com_next;
         frame_q <= frame_next;
      end
   end

   assign bus.seg         = seg_q;
   assign bus.com         = com_q;
   assign bus.frame_start = frame_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver. Two instances run side by side:
// A with SCAN_DIV=4/BLANK_CYCLES=1 and B with the minimum SCAN_DIV=2.
// Expected outputs are derived from the edge count since reset release.
module tb_seg_scan_driver;

   localparam int SD_A = 4;
   localparam int BL_A = 1;
   localparam int SD_B = 2;
   localparam int BL_B = 1;

   localparam logic [7:0] SEG_TAB [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'hFF, 8'hBF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

   logic clk;
   logic rst_n;
   logic [3:0] bcd [8];

   int testsRun;
   int testsFailed;

   int nA;
   int nB;
   logic [31:0] snapA;
   logic [31:0] snapB;
   logic [16:0] queueA [$];
   logic [16:0] queueB [$];

   seg_scan_driver_if ifA ();
   seg_scan_driver_if ifB ();

   assign ifA.bcd_in1 = bcd[0];
   assign ifA.bcd_in2 = bcd[1];
   assign ifA.bcd_in3 = bcd[2];
   assign ifA.bcd_in4 = bcd[3];
   assign ifA.bcd_in5 = bcd[4];
   assign ifA.bcd_in6 = bcd[5];
   assign ifA.bcd_in7 = bcd[6];
   assign ifA.bcd_in_led = bcd[7];
   assign ifB.bcd_in1 = bcd[0];
   assign ifB.bcd_in2 = bcd[1];
   assign ifB.bcd_in3 = bcd[2];
   assign ifB.bcd_in4 = bcd[3];
   assign ifB.bcd_in5 = bcd[4];
   assign ifB.bcd_in6 = bcd[5];
   assign ifB.bcd_in7 = bcd[6];
   assign ifB.bcd_in_led = bcd[7];

   seg_scan_driver #(.SCAN_DIV(SD_A), .BLANK_CYCLES(BL_A)) dutA (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifA)
   );

   seg_scan_driver #(.SCAN_DIV(SD_B), .BLANK_CYCLES(BL_B)) dutB (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time,
                  observed, expected);
      end
   endtask

   function automatic logic [31:0] packBcd();
      return {bcd[7], bcd[6], bcd[5], bcd[4], bcd[3], bcd[2], bcd[1], bcd[0]};
   endfunction

   // Expected {frame_start, com, seg} right after edge n (n=0 is the first
   // edge after reset release), using the snapshot valid for that frame.
   function automatic logic [16:0] modelOut(input int n, input int sd,
                                            input int bl, input logic [31:0] sn);
      int cnt;
      int idx;
      logic fs;
      logic [7:0] comE;
      logic [7:0] segE;
      logic [3:0] code;
      cnt  = n % sd;
      idx  = (n / sd) % 8;
      fs   = ((n % (8 * sd)) == 0);
      comE = 8'hFF;
      segE = 8'hFF;
      if (cnt >= bl) begin
         comE = ~(8'd1 << idx);
         code = sn[idx*4 +: 4];
         segE = SEG_TAB[code];
      end
      return {fs, comE, segE};
   endfunction

   // Predict each DUT's outputs at every active edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nA = 0;
         nB = 0;
         queueA.delete();
         queueB.delete();
      end else begin
         if ((nA % (8 * SD_A)) == 0) snapA = packBcd();
         if ((nB % (8 * SD_B)) == 0) snapB = packBcd();
         queueA.push_back(modelOut(nA, SD_A, BL_A, snapA));
         queueB.push_back(modelOut(nB, SD_B, BL_B, snapB));
         nA++;
         nB++;
      end
   end

   // Compare DUT outputs against predictions half a cycle after each edge.
   always @(negedge clk) begin
      logic [16:0] e;
      if (queueA.size() > 0) begin
         e = queueA.pop_front();
         checkOutput("A_frame_start", {7'd0, ifA.frame_start}, {7'd0, e[16]});
         checkOutput("A_com", ifA.com, e[15:8]);
         checkOutput("A_seg", ifA.seg, e[7:0]);
      end
      if (queueB.size() > 0) begin
         e = queueB.pop_front();
         checkOutput("B_frame_start", {7'd0, ifB.frame_start}, {7'd0, e[16]});
         checkOutput("B_com", ifB.com, e[15:8]);
         checkOutput("B_seg", ifB.seg, e[7:0]);
      end
   end

   task automatic applyStimulus(input logic [31:0] codes, input int cycles);
      for (int i = 0; i < 8; i++) bcd[i] = codes[i*4 +: 4];
      repeat (cycles) @(negedge clk);
   endtask

   initial begin
      int guard;
      testsRun    = 0;
      testsFailed = 0;
      rst_n = 1'b0;
      for (int i = 0; i < 8; i++) bcd[i] = 4'd0;

      // Reset state while held.
      #7;
      checkOutput("rst_com", ifA.com, 8'hFF);
      checkOutput("rst_seg", ifA.seg, 8'hFF);
      checkOutput("rst_fs", {7'd0, ifA.frame_start}, 8'd0);

      // Digits 1..8, released at a negedge; first edge takes the snapshot.
      @(negedge clk);
      for (int i = 0; i < 8; i++) bcd[i] = 4'(i + 1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("first_fs", {7'd0, ifA.frame_start}, 8'd1);
      checkOutput("first_com", ifA.com, 8'hFF);
      @(negedge clk);
      applyStimulus(32'h8765_4321, 64);

      // Change digit 3 while slot 1 of the current frame is showing.
      guard = 0;
      while (!(((nA % 32) >= 4) && ((nA % 32) < 8)) && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) checkOutput("wait_slot1", 8'd0, 8'd1);
      applyStimulus(32'h8765_4921, 72);

      // Alarm pattern: dashes on six digits, blanks on the last two.
      applyStimulus(32'hAABB_BBBB, 72);

      // Unused codes blank every digit.
      applyStimulus(32'hFEDC_CDEF, 72);

      // Random codes over a couple of frames.
      applyStimulus($urandom, 40);
      applyStimulus($urandom, 40);

      // Asynchronous reset while a common is active.
      applyStimulus(32'h0123_4567, 0);
      guard = 0;
      while (ifA.com == 8'hFF && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) checkOutput("wait_com_active", 8'd0, 8'd1);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_com", ifA.com, 8'hFF);
      checkOutput("async_seg", ifA.seg, 8'hFF);
      checkOutput("async_fs", {7'd0, ifA.frame_start}, 8'd0);
      checkOutput("async_com_B", ifB.com, 8'hFF);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("rerelease_fs", {7'd0, ifA.frame_start}, 8'd1);
      @(negedge clk);
      applyStimulus(32'h0123_4567, 40);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
